// File: rtl/axi_aw_burst_split_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_pkg
//  Description : Shared constants and types for the AXI4-to-AXI3 AW burst
//                splitter: burst encodings, AW attribute packing, FSM states.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_pkg;

    // AxBURST encodings; 2'b11 is reserved and handled like INCR
    localparam logic [1:0] BURST_FIXED = 2'd0;
    localparam logic [1:0] BURST_INCR  = 2'd1;
    localparam logic [1:0] BURST_WRAP  = 2'd2;
    localparam logic [1:0] BURST_RSVD  = 2'd3;

    // Field widths shared by the upstream and downstream channels
    localparam int AXI4_LEN_W = 8;
    localparam int AXI3_LEN_W = 4;
    localparam int SIZE_W     = 3;
    localparam int BURST_W    = 2;

    // Packed AW attributes: {lock[1:0], cache[3:0], prot[2:0], qos[3:0]}
    localparam int AWATTR_W       = 13;
    localparam int AWATTR_QOS_LSB   = 0;
    localparam int AWATTR_QOS_W     = 4;
    localparam int AWATTR_PROT_LSB  = 4;
    localparam int AWATTR_PROT_W    = 3;
    localparam int AWATTR_CACHE_LSB = 7;
    localparam int AWATTR_CACHE_W   = 4;
    localparam int AWATTR_LOCK_LSB  = 11;
    localparam int AWATTR_LOCK_W    = 2;

    // Splitter control states
    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_ISSUE = 1'b1
    } aw_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_aw_burst_split_if.sv
`default_nettype none
// ============================================================================
//  Module      : axi_aw_burst_split_if
//  Description : AW channel bundle for the burst splitter. Carries the
//                upstream AXI4 command, the downstream AXI3 chunk and the
//                WRAP-length error pulse. The slave modport is the splitter's
//                view; the master modport is the view of the surrounding
//                logic that drives commands and accepts chunks.
//  Revision    : 1.0 - initial release
// ============================================================================
interface axi_aw_burst_split_if
    import axi_pkg::*;
#(
    parameter int ID_MAX_WIDTH = 16,
    parameter int ADDR_WIDTH   = 32
) ();

    // Upstream AXI4 AW command
    logic                    s_awvalid;
    logic                    s_awready;
    logic [ID_MAX_WIDTH-1:0] s_awid;
    logic [ADDR_WIDTH-1:0]   s_awaddr;
    logic [AXI4_LEN_W-1:0]   s_awlen;
    logic [SIZE_W-1:0]       s_awsize;
    logic [BURST_W-1:0]      s_awburst;
    logic [AWATTR_W-1:0]     s_awattr;

    // Downstream AXI3 AW chunk
    logic                    m_awvalid;
    logic                    m_awready;
    logic [ID_MAX_WIDTH-1:0] m_awid;
    logic [ADDR_WIDTH-1:0]   m_awaddr;
    logic [AXI3_LEN_W-1:0]   m_awlen;
    logic [SIZE_W-1:0]       m_awsize;
    logic [BURST_W-1:0]      m_awburst;
    logic [AWATTR_W-1:0]     m_awattr;
    logic                    m_split_last;

    // Over-long WRAP command accepted
    logic                    err_wrap;

    modport slave (
        input  s_awvalid, s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awattr,
        input  m_awready,
        output s_awready,
        output m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awattr,
        output m_split_last, err_wrap
    );

    modport master (
        output s_awvalid, s_awid, s_awaddr, s_awlen, s_awsize, s_awburst, s_awattr,
        output m_awready,
        input  s_awready,
        input  m_awvalid, m_awid, m_awaddr, m_awlen, m_awsize, m_awburst, m_awattr,
        input  m_split_last, err_wrap
    );

endinterface
`default_nettype wire

// File: rtl/axi_aw_burst_split.sv
`default_nettype none
// ============================================================================
//  Module      : axi_aw_burst_split
//  Description : Splits one AXI4 AW command (up to 256 beats) into AXI3
//                chunks of at most MAX_BEATS beats. INCR (and reserved
//                burst 3) advances the address per chunk, FIXED keeps it,
//                WRAP is never split and flags lengths above MAX_BEATS.
//                MAX_BEATS must be a power of two in 2..16.
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_aw_burst_split
    import axi_pkg::*;
#(
    parameter int ID_MAX_WIDTH = 16,
    parameter int ADDR_WIDTH   = 32,
    parameter int MAX_BEATS    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    axi_aw_burst_split_if.slave  aw
);

    // Beat counter must hold 256 (AXI4 len 255 plus one)
    localparam int               REM_W       = 9;
    localparam logic [REM_W-1:0] MAX_BEATS_R = REM_W'(MAX_BEATS);

    aw_state_e               state_q,    state_d;
    logic [REM_W-1:0]        remaining_q, remaining_d;
    logic [ADDR_WIDTH-1:0]   addr_q,     addr_d;
    logic [ID_MAX_WIDTH-1:0] id_q,       id_d;
    logic [SIZE_W-1:0]       size_q,     size_d;
    logic [BURST_W-1:0]      burst_q,    burst_d;
    logic [AWATTR_W-1:0]     attr_q,     attr_d;
    logic [AXI3_LEN_W-1:0]   wrap_len_q, wrap_len_d;
    logic                    err_wrap_q, err_wrap_d;

    logic                    w_issue;
    logic                    w_wrap;
    logic                    w_last;
    logic [REM_W-1:0]        w_chunk_beats;
    logic [AXI3_LEN_W-1:0]   w_chunk_len;
    logic [ADDR_WIDTH-1:0]   w_step;

    // Current-chunk decode from the captured command and beats still owed
    always_comb begin
        w_issue       = (state_q == ST_ISSUE);
        w_wrap        = (burst_q == BURST_WRAP);
        w_last        = w_wrap || (remaining_q <= MAX_BEATS_R);
        w_chunk_beats = (remaining_q <= MAX_BEATS_R) ? remaining_q : MAX_BEATS_R;
        w_chunk_len   = w_wrap ? wrap_len_q
                               : AXI3_LEN_W'(w_chunk_beats - REM_W'(1));
        w_step        = ADDR_WIDTH'(MAX_BEATS) << size_q;
    end

    // Next-state logic: accept in IDLE, emit and advance chunks in ISSUE
    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        id_d        = id_q;
        size_d      = size_q;
        burst_d     = burst_q;
        attr_d      = attr_q;
        wrap_len_d  = wrap_len_q;
        err_wrap_d  = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (aw.s_awvalid) begin
                    remaining_d = REM_W'(aw.s_awlen) + REM_W'(1);
                    addr_d      = aw.s_awaddr;
                    id_d        = aw.s_awid;
                    size_d      = aw.s_awsize;
                    burst_d     = aw.s_awburst;
                    attr_d      = aw.s_awattr;
                    wrap_len_d  = aw.s_awlen[AXI3_LEN_W-1:0];
                    err_wrap_d  = (aw.s_awburst == BURST_WRAP) &&
                                  (aw.s_awlen > AXI4_LEN_W'(MAX_BEATS - 1));
                    state_d     = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (aw.m_awready) begin
                    if (w_last) begin
                        remaining_d = '0;
                        state_d     = ST_IDLE;
                    end else begin
                        remaining_d = remaining_q - MAX_BEATS_R;
                        // WRAP never reaches here, so only FIXED holds the address
                        if (burst_q != BURST_FIXED) begin
                            addr_d = addr_q + w_step;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and captured-command registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            remaining_q <= '0;
            addr_q      <= '0;
            id_q        <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            attr_q      <= '0;
            wrap_len_q  <= '0;
            err_wrap_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            id_q        <= id_d;
            size_q      <= size_d;
            burst_q     <= burst_d;
            attr_q      <= attr_d;
            wrap_len_q  <= wrap_len_d;
            err_wrap_q  <= err_wrap_d;
        end
    end

    // Ready depends only on state, never on m_awready
    assign aw.s_awready    = (state_q == ST_IDLE);

    // Downstream chunk; all fields come from registers so they hold while stalled
    assign aw.m_awvalid    = w_issue;
    assign aw.m_awid       = id_q;
    assign aw.m_awaddr     = addr_q;
    assign aw.m_awlen      = w_issue ? w_chunk_len : '0;
    assign aw.m_awsize     = size_q;
    assign aw.m_awburst    = burst_q;
    assign aw.m_awattr     = attr_q;
    assign aw.m_split_last = w_issue && w_last;
    assign aw.err_wrap     = err_wrap_q;

endmodule
`default_nettype wire

// File: doc/axi_aw_burst_split.md
AXI_AW_BURST_SPLIT -- requirements
Module: axi_aw_burst_split

Interface
REQ-001 SHALL have parameter ID_MAX_WIDTH, default 16, AW ID width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 32, address width.
REQ-003 SHALL have parameter MAX_BEATS, default 16, max beats per output burst; power of two, 2..16.
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk, rst.
REQ-005 clk  in  1  sole clock; all state updates on rising edge.
REQ-006 rst  in  1  synchronous active-high reset.
REQ-007 s_awvalid  in  1  upstream AXI4 AW valid.
REQ-008 s_awready  out  1  upstream ready.
REQ-009 s_awid  in  ID_MAX_WIDTH  command ID.
REQ-010 s_awaddr  in  ADDR_WIDTH  start address.
REQ-011 s_awlen  in  8  AXI4 beats minus one (1..256 beats).
REQ-012 s_awsize  in  3  bytes per beat = 2^size.
REQ-013 s_awburst  in  2  0 FIXED, 1 INCR, 2 WRAP.
REQ-014 s_awattr  in  13  packed {lock[1:0], cache[3:0], prot[2:0], qos[3:0]}.
REQ-015 m_awvalid  out  1  downstream AW valid.
REQ-016 m_awready  in  1  downstream ready.
REQ-017 m_awid, m_awaddr, m_awsize, m_awburst, m_awattr  out  same widths as s_*  chunk fields.
REQ-018 m_awlen  out  4  AXI3 chunk beats minus one.
REQ-019 m_split_last  out  1  high with m_awvalid on final chunk of a command.
REQ-020 err_wrap  out  1  one-cycle pulse: WRAP command with s_awlen > MAX_BEATS-1 accepted.

Function
REQ-021 States IDLE, ISSUE; s_awready = (state == IDLE), no combinational path from m_awready.
REQ-022 On s_awvalid && s_awready: capture all s_* fields, remaining = s_awlen+1, go ISSUE; m_awvalid high the next cycle (latency 1).
REQ-023 In ISSUE: m_awvalid = 1; m_awlen = min(remaining, MAX_BEATS) - 1; m_split_last = (remaining <= MAX_BEATS); id/size/burst/attr = captured values.
REQ-024 On m_awvalid && m_awready with m_split_last = 1: go IDLE; s_awready high the following cycle (one bubble between commands).
REQ-025 On m_awvalid && m_awready with m_split_last = 0: remaining -= MAX_BEATS; INCR addr += MAX_BEATS << size, modulo 2^ADDR_WIDTH; FIXED addr unchanged; stay ISSUE.
REQ-026 WRAP SHALL NOT split: one chunk, m_awlen = s_awlen[3:0], m_split_last = 1; err_wrap pulses the cycle after acceptance if s_awlen > MAX_BEATS-1.
REQ-027 Burst value 3 (reserved) SHALL be treated as INCR.
REQ-028 While m_awvalid && !m_awready, all m_* outputs SHALL hold stable.
REQ-029 4 KB-boundary legality is the requester's responsibility; no boundary check.

Reset
REQ-030 rst SHALL force IDLE, m_awvalid = 0, m_split_last = 0, err_wrap = 0, all m_* data = 0, remaining = 0; s_awready = 1 the cycle after rst deasserts.
REQ-031 rst mid-ISSUE SHALL drop the in-flight command; no further chunks are issued.

Structure
REQ-032 Shared package axi_pkg SHALL hold burst-type constants, state enum, and AWATTR_W = 13 with field offsets.
REQ-033 Single flat module; no sub-modules.

Verification
REQ-034 INCR addr 0x1000, len 0x00, size 3 -> one chunk addr 0x1000, len 0, m_split_last = 1, m_awvalid 1 cycle after accept.
REQ-035 INCR addr 0x2000, len 0x3F, size 2, m_awready = 1 -> chunks 0x2000/0x2040/0x2080/0x20C0, len 0xF each, m_split_last only on 4th, back-to-back cycles.
REQ-036 INCR addr 0xFFFF_FFC0, len 0x12, size 2 -> chunk len 0xF at 0xFFFF_FFC0, then len 0x2 at 0x0000_0000 (wrap-around).
REQ-037 FIXED addr 0x3000, len 0x20 -> three chunks at 0x3000, len 0xF, 0xF, 0x0.
REQ-038 INCR len 0x3F, m_awready low 5 cycles on chunk 2 -> m_* stable throughout, s_awready = 0; WRAP len 0x1F -> single chunk len 0xF, err_wrap one pulse.
REQ-039 rst asserted during chunk 2 of len 0x3F -> m_awvalid = 0 next cycle, s_awready = 1 after release, no remaining chunks issued.
